sha256_block_sequencer: RTL and testbench

//  Streams pre-padded 512-bit message blocks into the SHA-256 core over a 32-bit

---
 rtl/sha256_block_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// Buffers one 512-bit block from a 32-bit valid/ready stream, feeds it to the SHA-256 core and returns the digest.
// Input stalls (ready low) from the last word of a block until the core finishes; the digest is held until accepted.
module sha256_block_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iAbort,
   input  logic              iWord_valid,
   output logic              oWord_ready,
   input  logic [31:0]       iWord_data,
   input  logic              iMsg_first,
   input  logic              iMsg_last,
   output logic              oCore_start,
   output logic              oCore_data_valid,
   output logic [31:0]       oCore_data,
   input  logic [3:0]        iCore_load_counter,
   input  logic              iCore_done,
   output logic              oCore_new_input_n,
   input  logic [255:0]      iCore_hash,
   output logic              oDigest_valid,
   input  logic              iDigest_ready,
   output logic [255:0]      oDigest,
   output logic              oBusy,
   output logic [CNT_W-1:0]  oBlock_count,
   output logic              oError
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CLEAR,
      S_FEED,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [3:0]        idx;
   logic              first_q;
   logic              last_q;
   logic              msg_active;
   logic              done_q;
   logic [TO_W-1:0]   wait_cnt;
   logic [31:0]       word_buf [16];
   logic              word_acc;
   logic              done_rise;
   logic              timed_out;

   assign word_acc  = iWord_valid & oWord_ready;
   assign done_rise = iCore_done & ~done_q;
   assign timed_out = (wait_cnt >= TO_W'(TIMEOUT_CYCLES));

   assign oCore_data        = word_buf[iCore_load_counter];
   assign oCore_start       = (state == S_FEED);
   assign oCore_data_valid  = (state == S_FEED);
   assign oCore_new_input_n = (state != S_CLEAR);
   assign oDigest_valid     = (state == S_HOLD);
   assign oBusy             = (state != S_IDLE);

   always_ff @(posedge iClk) begin
      if (!iReset_n || iAbort) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (word_acc) state_next = S_FILL;
         end
         S_FILL: begin
            if (word_acc && idx == 4'd15) begin
               state_next = (first_q || !msg_active) ? S_CLEAR : S_FEED;
            end
         end
         S_CLEAR: begin
            state_next = S_FEED;
         end
         S_FEED: begin
            if (iCore_load_counter == 4'd15) state_next = S_WAIT;
         end
         S_WAIT: begin
            if (done_rise) begin
               state_next = last_q ? S_HOLD : S_FILL;
            end else if (timed_out) begin
               state_next = S_IDLE;
            end
         end
         S_HOLD: begin
            if (iDigest_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Buffer contents are don't-care until all 16 words are written, so no reset.
   always_ff @(posedge iClk) begin
      if (word_acc) begin
         word_buf[idx] <= iWord_data;
      end
   end

   // Sampling done every cycle means the register already holds the current level
   // on WAIT entry, so a done left high from the previous block is not an edge.
   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= iCore_done;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         oWord_ready  <= 1'b0;
         idx          <= 4'd0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         msg_active   <= 1'b0;
         wait_cnt     <= '0;
         oError       <= 1'b0;
         oBlock_count <= '0;
         oDigest      <= '0;
      end else if (iAbort) begin
         oWord_ready  <= 1'b0;
         idx          <= 4'd0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         msg_active   <= 1'b0;
         wait_cnt     <= '0;
         oError       <= 1'b0;
      end else begin
         oWord_ready <= (state_next == S_IDLE) || (state_next == S_FILL);

         // idx wraps 15 -> 0, which leaves it ready for the next block.
         if (word_acc) begin
            idx <= idx + 4'd1;
            if (idx == 4'd0) begin
               first_q <= iMsg_first;
               last_q  <= iMsg_last;
            end
         end

         if (state == S_CLEAR) begin
            msg_active   <= 1'b1;
            oBlock_count <= '0;
         end

         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end

         if (state == S_WAIT) begin
            if (done_rise) begin
               if (oBlock_count != '1) begin
                  oBlock_count <= oBlock_count + 1'b1;
               end
               if (last_q) begin
                  oDigest    <= iCore_hash;
                  msg_active <= 1'b0;
               end
            end else if (timed_out) begin
               oError     <= 1'b1;
               msg_active <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench: behavioural SHA-256 core model plus a digest scoreboard checked by an independent monitor.
module tb_sha256_block_sequencer;

   logic          iClk = 1'b0;
   logic          iReset_n;
   logic          iAbort;
   logic          iWord_valid;
   logic          oWord_ready;
   logic [31:0]   iWord_data;
   logic          iMsg_first;
   logic          iMsg_last;
   logic          oCore_start;
   logic          oCore_data_valid;
   logic [31:0]   oCore_data;
   logic [3:0]    iCore_load_counter;
   logic          iCore_done;
   logic          oCore_new_input_n;
   logic [255:0]  iCore_hash;
   logic          oDigest_valid;
   logic          iDigest_ready;
   logic [255:0]  oDigest;
   logic          oBusy;
   logic [15:0]   oBlock_count;
   logic          oError;

   always #5 iClk = ~iClk;

   sha256_block_sequencer #(.TIMEOUT_CYCLES(1024), .CNT_W(16)) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iAbort(iAbort),
      .iWord_valid(iWord_valid), .oWord_ready(oWord_ready), .iWord_data(iWord_data),
      .iMsg_first(iMsg_first), .iMsg_last(iMsg_last),
      .oCore_start(oCore_start), .oCore_data_valid(oCore_data_valid), .oCore_data(oCore_data),
      .iCore_load_counter(iCore_load_counter), .iCore_done(iCore_done),
      .oCore_new_input_n(oCore_new_input_n), .iCore_hash(iCore_hash),
      .oDigest_valid(oDigest_valid), .iDigest_ready(iDigest_ready), .oDigest(oDigest),
      .oBusy(oBusy), .oBlock_count(oBlock_count), .oError(oError)
   );

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] BLK_ABC = {32'h61626380, {13{32'h0}}, 32'h00000000, 32'h00000018};
   localparam logic [511:0] BLK_2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_2B  = {{15{32'h0}}, 32'h000001c0};
   localparam logic [511:0] BLK_JUNK = {16{32'hdeadbeef}};
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
         s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // Core model: one word per cycle while START/DATA_VALID, done a fixed delay later.
   logic [511:0] core_blk;
   logic [255:0] core_h;
   int           core_busy;
   bit           core_hang;

   assign iCore_hash = core_h;

   always @(posedge iClk) begin
      if (!iReset_n) begin
         iCore_load_counter <= 4'd0;
         iCore_done         <= 1'b0;
         core_busy          <= 0;
         core_h             <= '0;
      end else begin
         if (!oCore_new_input_n) core_h <= IV;
         if (oCore_start && oCore_data_valid) begin
            core_blk[511 - 32*int'(iCore_load_counter) -: 32] <= oCore_data;
            iCore_done <= 1'b0;
            if (iCore_load_counter == 4'd15) begin
               iCore_load_counter <= 4'd0;
               core_busy          <= 20;
            end else begin
               iCore_load_counter <= iCore_load_counter + 4'd1;
            end
         end else if (core_busy > 0) begin
            core_busy <= core_busy - 1;
            if (core_busy == 1 && !core_hang) begin
               core_h     <= sha_compress(core_h, core_blk);
               iCore_done <= 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [255:0] dig;
      int           cnt;
   } exp_t;

   exp_t exp_q [$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   nin_low  = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   // Monitor: compares every accepted digest against the scoreboard head.
   always @(negedge iClk) begin
      if (!oCore_new_input_n) nin_low++;
      if (oDigest_valid && iDigest_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_digest: got %h, none queued", oDigest);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("digest", oDigest, e.dig);
            check("block_count", 256'(oBlock_count), 256'(e.cnt));
         end
      end
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic send_words(input logic [511:0] blk, input int n, input logic first, input logic last);
      for (int i = 0; i < n; i++) begin
         int cnt;
         iWord_valid = 1'b1;
         iWord_data  = blk[511 - 32*i -: 32];
         iMsg_first  = first;
         iMsg_last   = last;
         cnt = 0;
         while (!oWord_ready && cnt < 300) begin
            tick();
            cnt++;
         end
         if (!oWord_ready) begin
            check("word_ready_timeout", 256'(oWord_ready), 256'(1));
            iWord_valid = 1'b0;
            return;
         end
         tick();
      end
      iWord_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || oBusy) && cnt < 3000) begin
         tick();
         cnt++;
      end
      check(name, 256'(cnt < 3000), 256'(1));
   endtask

   task automatic push(input logic [255:0] dig, input int cnt);
      exp_t e;
      e.dig = dig;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int cnt;
      int bad_v, bad_d, bad_r;
      iReset_n = 1'b0;
      iAbort = 1'b0;
      iWord_valid = 1'b0;
      iWord_data = '0;
      iMsg_first = 1'b0;
      iMsg_last = 1'b0;
      iDigest_ready = 1'b1;
      core_hang = 1'b0;
      repeat (3) tick();

      check("rst_ready", 256'(oWord_ready), 256'(0));
      check("rst_busy", 256'(oBusy), 256'(0));
      check("rst_new_input_n", 256'(oCore_new_input_n), 256'(1));
      check("rst_start", 256'(oCore_start), 256'(0));
      check("rst_digest", oDigest, 256'(0));
      check("rst_count", 256'(oBlock_count), 256'(0));
      check("rst_error", 256'(oError), 256'(0));
      iReset_n = 1'b1;
      tick();
      check("ready_after_rst", 256'(oWord_ready), 256'(1));

      // "abc" single block
      nin_low = 0;
      push(DIG_ABC, 1);
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      drain("abc_done");
      check("abc_clear_once", 256'(nin_low), 256'(1));

      // two-block message, chaining value carried across blocks
      nin_low = 0;
      push(DIG_2BLK, 2);
      send_words(BLK_2A, 16, 1'b1, 1'b0);
      send_words(BLK_2B, 16, 1'b0, 1'b1);
      drain("twoblk_done");
      check("twoblk_clear_once", 256'(nin_low), 256'(1));

      // digest backpressure
      iDigest_ready = 1'b0;
      push(DIG_ABC, 1);
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      cnt = 0;
      while (!oDigest_valid && cnt < 300) begin
         tick();
         cnt++;
      end
      check("hold_reached", 256'(oDigest_valid), 256'(1));
      bad_v = 0; bad_d = 0; bad_r = 0;
      for (int i = 0; i < 50; i++) begin
         if (!oDigest_valid) bad_v++;
         if (oDigest !== DIG_ABC) bad_d++;
         if (oWord_ready) bad_r++;
         tick();
      end
      check("hold_valid_drops", 256'(bad_v), 256'(0));
      check("hold_digest_changes", 256'(bad_d), 256'(0));
      check("hold_ready_high", 256'(bad_r), 256'(0));
      iDigest_ready = 1'b1;
      drain("hold_release");
      check("idle_ready_after_hold", 256'(oWord_ready), 256'(1));

      // core never completes
      core_hang = 1'b1;
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      cnt = 0;
      while (!oError && cnt < 3000) begin
         tick();
         cnt++;
      end
      check("timeout_error", 256'(oError), 256'(1));
      check("timeout_window", 256'(cnt >= 1024 && cnt <= 1060), 256'(1));
      check("timeout_busy", 256'(oBusy), 256'(0));
      check("timeout_ready", 256'(oWord_ready), 256'(1));
      check("timeout_count", 256'(oBlock_count), 256'(0));
      core_hang = 1'b0;
      repeat (30) tick();
      check("error_sticky", 256'(oError), 256'(1));

      // abort a partially filled block
      send_words(BLK_JUNK, 7, 1'b1, 1'b1);
      iAbort = 1'b1;
      tick();
      iAbort = 1'b0;
      check("abort_error_clear", 256'(oError), 256'(0));
      check("abort_busy", 256'(oBusy), 256'(0));
      check("abort_ready", 256'(oWord_ready), 256'(0));
      check("abort_keeps_digest", oDigest, DIG_ABC);
      push(DIG_ABC, 1);
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      drain("abort_abc_done");

      // reset in the middle of the core feed
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      cnt = 0;
      while (!oCore_start && cnt < 50) begin
         tick();
         cnt++;
      end
      check("feed_reached", 256'(oCore_start), 256'(1));
      repeat (3) tick();
      iReset_n = 1'b0;
      tick();
      check("rstfeed_start", 256'(oCore_start), 256'(0));
      check("rstfeed_valid", 256'(oCore_data_valid), 256'(0));
      check("rstfeed_ready", 256'(oWord_ready), 256'(0));
      check("rstfeed_new_input_n", 256'(oCore_new_input_n), 256'(1));
      check("rstfeed_digest", oDigest, 256'(0));
      iReset_n = 1'b1;
      push(DIG_ABC, 1);
      send_words(BLK_ABC, 16, 1'b1, 1'b1);
      drain("rstfeed_abc_done");

      check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
